// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD write controller: power-up delay, init ROM playback, then a
// valid/ready byte interface. Supports the 8-bit bus and the 4-bit (two-nibble) bus.
module lcd_hd44780_ctrl #(
  parameter int unsigned PWRUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC    = 3,
  parameter int unsigned EN_HIGH_CYC  = 25,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned BUS_4BIT     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int unsigned MaxAB  = (PWRUP_CYC > SETUP_CYC) ? PWRUP_CYC : SETUP_CYC;
  localparam int unsigned MaxCD  = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
  localparam int unsigned MaxCDE = (MaxCD > CLR_WAIT_CYC) ? MaxCD : CLR_WAIT_CYC;
  localparam int unsigned MaxCyc = (MaxAB > MaxCDE) ? MaxAB : MaxCDE;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [3:0]  RomLen = (BUS_4BIT != 0) ? 4'd8 : 4'd7;

  typedef enum logic [2:0] {
    StPwrup, StInitLoad, StSetup, StEnHi, StHold, StWait, StIdle
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  state_e            w_load_dst;
  state_e            w_done_dst;
  logic [CntW-1:0]   r_cnt;
  logic [3:0]        r_rom_idx;
  logic              r_init_done;
  logic [7:0]        r_lcd_data;
  logic              r_lcd_rs;
  logic [3:0]        r_lo_nib;
  logic              r_nib_pend;
  logic              r_long_wait;

  logic [7:0]        w_rom_byte;
  logic              w_rom_single;
  logic              w_accept;
  logic              w_ld_en;
  logic [7:0]        w_ld_byte;
  logic              w_ld_rs;
  logic              w_ld_split;
  logic              w_ld_first;
  logic              w_counting;
  logic [31:0]       w_wait_n;
  logic              w_pwrup_last;
  logic              w_setup_last;
  logic              w_en_last;
  logic              w_wait_last;

  // Init ROM; 4-bit entries flagged single are sent as one high nibble only.
  always_comb begin
    w_rom_byte   = 8'h00;
    w_rom_single = 1'b0;
    if (BUS_4BIT != 0) begin
      case (r_rom_idx)
        4'd0, 4'd1, 4'd2: begin w_rom_byte = 8'h30; w_rom_single = 1'b1; end
        4'd3:    begin w_rom_byte = 8'h20; w_rom_single = 1'b1; end
        4'd4:    w_rom_byte = 8'h28;
        4'd5:    w_rom_byte = 8'h0C;
        4'd6:    w_rom_byte = 8'h01;
        4'd7:    w_rom_byte = 8'h06;
        default: w_rom_byte = 8'h00;
      endcase
    end else begin
      case (r_rom_idx)
        4'd0, 4'd1, 4'd2: w_rom_byte = 8'h30;
        4'd3:    w_rom_byte = 8'h38;
        4'd4:    w_rom_byte = 8'h0C;
        4'd5:    w_rom_byte = 8'h01;
        4'd6:    w_rom_byte = 8'h06;
        default: w_rom_byte = 8'h00;
      endcase
    end
  end

  assign w_accept     = in_valid && in_ready;
  assign w_ld_en      = (r_state == StInitLoad) || w_accept;
  assign w_ld_byte    = (r_state == StInitLoad) ? w_rom_byte : in_data;
  assign w_ld_rs      = (r_state == StInitLoad) ? 1'b0 : in_rs;
  assign w_ld_split   = (r_state == StInitLoad) ? !w_rom_single : 1'b1;
  assign w_ld_first   = (r_state == StInitLoad) && (r_rom_idx == 4'd0);

  assign w_wait_n     = r_long_wait ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  assign w_pwrup_last = (r_cnt == CntW'(PWRUP_CYC - 1));
  assign w_setup_last = (r_cnt == CntW'(SETUP_CYC - 1));
  assign w_en_last    = (r_cnt == CntW'(EN_HIGH_CYC - 1));
  assign w_wait_last  = (r_cnt == CntW'(w_wait_n - 32'd1));
  assign w_counting   = (r_state == StPwrup) || (r_state == StSetup) ||
                        (r_state == StEnHi) || (r_state == StWait);

  always_comb begin
    w_load_dst = StSetup;
    if (SETUP_CYC == 0) w_load_dst = StEnHi;
    w_done_dst = StInitLoad;
    if (r_init_done || (r_rom_idx == RomLen)) w_done_dst = StIdle;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StPwrup;
    else      r_state <= w_state_d;
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StPwrup:    if ((PWRUP_CYC == 0) || w_pwrup_last) w_state_d = StInitLoad;
      StInitLoad: w_state_d = w_load_dst;
      StSetup:    if (w_setup_last) w_state_d = StEnHi;
      StEnHi:     if (w_en_last) w_state_d = StHold;
      StHold: begin
        if (r_nib_pend)           w_state_d = w_load_dst;
        else if (w_wait_n == 0)   w_state_d = w_done_dst;
        else                      w_state_d = StWait;
      end
      StWait:     if (w_wait_last) w_state_d = w_done_dst;
      StIdle:     if (w_accept) w_state_d = w_load_dst;
      default:    w_state_d = StPwrup;
    endcase
  end

  // FSM: outputs (lcd_en decodes the async-reset state, so reset drops it at once)
  always_comb begin
    lcd_en   = (r_state == StEnHi);
    busy     = (r_state != StIdle);
    in_ready = (r_state == StIdle) && r_init_done;
  end

  // Shared cycle counter restarts on every state change and never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_cnt <= '0;
    else if (w_state_d != r_state)   r_cnt <= '0;
    else if (w_counting)             r_cnt <= r_cnt + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rom_idx   <= 4'd0;
      r_init_done <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_lcd_rs    <= 1'b0;
      r_lo_nib    <= 4'h0;
      r_nib_pend  <= 1'b0;
      r_long_wait <= 1'b0;
    end else begin
      if (w_state_d == StIdle) r_init_done <= 1'b1;
      if (r_state == StInitLoad) r_rom_idx <= r_rom_idx + 4'd1;
      if (w_ld_en) begin
        r_lcd_rs    <= w_ld_rs;
        r_lcd_data  <= (BUS_4BIT != 0) ? {w_ld_byte[7:4], 4'h0} : w_ld_byte;
        r_lo_nib    <= w_ld_byte[3:0];
        r_nib_pend  <= (BUS_4BIT != 0) && w_ld_split;
        r_long_wait <= w_ld_first || (!w_ld_rs && (w_ld_byte[7:2] == 6'd0));
      end else if ((r_state == StHold) && r_nib_pend) begin
        r_lcd_data <= {r_lo_nib, 4'h0};
        r_nib_pend <= 1'b0;
      end
    end
  end

  assign init_done = r_init_done;
  assign lcd_data  = r_lcd_data;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: an 8-bit and a 4-bit instance share clock and reset.
module tb_lcd_hd44780_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, a_rs = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_ready, a_done, a_busy, a_rw, a_lcd_rs, a_en;
  logic [7:0] a_lcd_data;
  logic       b_valid = 1'b0, b_rs = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_ready, b_done, b_busy, b_rw, b_lcd_rs, b_en;
  logic [7:0] b_lcd_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .PWRUP_CYC(20), .SETUP_CYC(2), .EN_HIGH_CYC(4), .CMD_WAIT_CYC(10), .CLR_WAIT_CYC(30),
    .BUS_4BIT(0)
  ) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_rs(a_rs), .in_data(a_data),
    .in_ready(a_ready), .init_done(a_done), .busy(a_busy), .lcd_data(a_lcd_data),
    .lcd_rw(a_rw), .lcd_rs(a_lcd_rs), .lcd_en(a_en)
  );

  lcd_hd44780_ctrl #(
    .PWRUP_CYC(20), .SETUP_CYC(2), .EN_HIGH_CYC(4), .CMD_WAIT_CYC(10), .CLR_WAIT_CYC(30),
    .BUS_4BIT(1)
  ) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_rs(b_rs), .in_data(b_data),
    .in_ready(b_ready), .init_done(b_done), .busy(b_busy), .lcd_data(b_lcd_data),
    .lcd_rw(b_rw), .lcd_rs(b_lcd_rs), .lcd_en(b_en)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (a_en !== 1'b0) $display("FAIL reset_en: got %b want 0", a_en);
    else n_pass++;
    n_checks++; if (a_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", a_ready);
    else n_pass++;
    n_checks++; if (a_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", a_busy);
    else n_pass++;
    n_checks++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b want 0", a_done);
    else n_pass++;
    n_checks++;
    if ({a_lcd_data, a_lcd_rs, a_rw} !== 10'h000)
      $display("FAIL reset_bus: got data=%h rs=%b rw=%b want 00/0/0", a_lcd_data, a_lcd_rs, a_rw);
    else n_pass++;
    n_checks++;
    if ({b_en, b_lcd_data, b_ready} !== 10'h000)
      $display("FAIL reset_4bit: got en=%b data=%h ready=%b want 0/00/0", b_en, b_lcd_data, b_ready);
    else n_pass++;
  endtask

  task automatic test_init;
    int         exp_rise[7] = '{23, 61, 79, 97, 115, 133, 171};
    logic [7:0] exp_a[7]    = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
    logic [7:0] exp_b[12]   = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
                                8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};
    int         a_rise[$];
    logic [7:0] a_byte[$];
    logic [7:0] b_byte[$];
    int         a_done_cyc = -1, b_done_cyc = -1;
    logic       a_prev = 1'b0, b_prev = 1'b0, rs_bad = 1'b0, low_bad = 1'b0;
    rst = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (a_en && !a_prev) begin
        a_rise.push_back(cyc);
        a_byte.push_back(a_lcd_data);
        if (a_lcd_rs !== 1'b0) rs_bad = 1'b1;
      end
      if (b_en && !b_prev) b_byte.push_back(b_lcd_data);
      if (b_lcd_data[3:0] !== 4'h0) low_bad = 1'b1;
      if (a_done && a_done_cyc < 0) a_done_cyc = cyc;
      if (b_done && b_done_cyc < 0) b_done_cyc = cyc;
      a_prev = a_en;
      b_prev = b_en;
      tick();
    end
    n_checks++; if (a_rise.size() != 7) $display("FAIL init8_count: got %0d want 7", a_rise.size());
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (i >= a_rise.size() || a_rise[i] != exp_rise[i] || a_byte[i] !== exp_a[i])
        $display("FAIL init8_pulse%0d: got cyc=%0d byte=%h want cyc=%0d byte=%h", i,
                 (i < a_rise.size()) ? a_rise[i] : -1, (i < a_byte.size()) ? a_byte[i] : 8'hxx,
                 exp_rise[i], exp_a[i]);
      else n_pass++;
    end
    n_checks++; if (rs_bad) $display("FAIL init8_rs: got rs=1 during init want 0");
    else n_pass++;
    n_checks++; if (a_done_cyc != 186) $display("FAIL init8_done: got cyc=%0d want 186", a_done_cyc);
    else n_pass++;
    n_checks++; if (b_byte.size() != 12) $display("FAIL init4_count: got %0d want 12", b_byte.size());
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (i >= b_byte.size() || b_byte[i] !== exp_b[i])
        $display("FAIL init4_nib%0d: got %h want %h", i,
                 (i < b_byte.size()) ? b_byte[i] : 8'hxx, exp_b[i]);
      else n_pass++;
    end
    n_checks++; if (low_bad) $display("FAIL init4_low: got nonzero lcd_data[3:0] want 0");
    else n_pass++;
    n_checks++; if (b_done_cyc != 232) $display("FAIL init4_done: got cyc=%0d want 232", b_done_cyc);
    else n_pass++;
  endtask

  task automatic test_char_write;
    int   rise = -1, high = 0, back = -1;
    logic prev = 1'b0, rs_at = 1'b0;
    logic [7:0] data_at = 8'h00;
    n_checks++; if (a_ready !== 1'b1) $display("FAIL char_ready_pre: got %b want 1", a_ready);
    else n_pass++;
    a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h41;
    tick();
    a_valid = 1'b0; a_rs = 1'b0; a_data = 8'h00;
    for (int k = 1; k <= 60; k++) begin
      if (a_en && !prev && rise < 0) begin rise = k; rs_at = a_lcd_rs; data_at = a_lcd_data; end
      if (a_en) high++;
      if (a_ready && back < 0) back = k;
      prev = a_en;
      tick();
    end
    n_checks++; if (rise != 3) $display("FAIL char_rise: got %0d want 3", rise);
    else n_pass++;
    n_checks++;
    if (data_at !== 8'h41 || rs_at !== 1'b1)
      $display("FAIL char_bus: got data=%h rs=%b want 41/1", data_at, rs_at);
    else n_pass++;
    n_checks++; if (high != 4) $display("FAIL char_en_width: got %0d want 4", high);
    else n_pass++;
    n_checks++; if (back != 18) $display("FAIL char_ready_low: got %0d want 17", back - 1);
    else n_pass++;
    n_checks++; if (a_lcd_data !== 8'h41) $display("FAIL char_idle_hold: got %h want 41", a_lcd_data);
    else n_pass++;
  endtask

  task automatic test_clear_cmd;
    int   pulses = 0, back = -1;
    logic prev = 1'b0;
    a_valid = 1'b1; a_rs = 1'b0; a_data = 8'h01;
    tick();
    a_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h80; end
      if (k == 6) begin a_valid = 1'b0; a_rs = 1'b0; a_data = 8'h00; end
      if (a_en && !prev) pulses++;
      if (a_ready && back < 0) back = k;
      prev = a_en;
      tick();
    end
    n_checks++; if (back != 38) $display("FAIL clr_ready_low: got %0d want 37", back - 1);
    else n_pass++;
    n_checks++; if (pulses != 1) $display("FAIL clr_not_queued: got %0d pulses want 1", pulses);
    else n_pass++;
    n_checks++;
    if (a_lcd_data !== 8'h01 || a_lcd_rs !== 1'b0)
      $display("FAIL clr_idle_hold: got data=%h rs=%b want 01/0", a_lcd_data, a_lcd_rs);
    else n_pass++;
  endtask

  task automatic test_4bit_write;
    int         rise[$];
    logic [7:0] dat[$];
    int         back = -1;
    logic       prev = 1'b0, bad = 1'b0;
    b_valid = 1'b1; b_rs = 1'b1; b_data = 8'hA5;
    tick();
    b_valid = 1'b0; b_rs = 1'b0; b_data = 8'h00;
    for (int k = 1; k <= 60; k++) begin
      if (b_en && !prev) begin rise.push_back(k); dat.push_back(b_lcd_data); end
      if (b_lcd_data[3:0] !== 4'h0 || (back < 0 && b_lcd_rs !== 1'b1)) bad = 1'b1;
      if (b_ready && back < 0) back = k;
      prev = b_en;
      tick();
    end
    n_checks++;
    if (rise.size() != 2 || rise[0] != 3 || rise[1] != 10)
      $display("FAIL nib_timing: got %0d pulses first=%0d second=%0d want 2 at 3,10", rise.size(),
               (rise.size() > 0) ? rise[0] : -1, (rise.size() > 1) ? rise[1] : -1);
    else n_pass++;
    n_checks++;
    if (dat.size() != 2 || dat[0] !== 8'hA0 || dat[1] !== 8'h50)
      $display("FAIL nib_data: got %h,%h want A0,50", (dat.size() > 0) ? dat[0] : 8'hxx,
               (dat.size() > 1) ? dat[1] : 8'hxx);
    else n_pass++;
    n_checks++; if (bad) $display("FAIL nib_bus: got low nibble nonzero or rs=0 want 0/1");
    else n_pass++;
    n_checks++; if (back != 25) $display("FAIL nib_ready_low: got %0d want 24", back - 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse;
    int         a_first = -1, b_first = -1;
    logic [7:0] a_byte = 8'h00, b_byte = 8'h00;
    a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h42;
    tick();
    a_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (a_en !== 1'b1) $display("FAIL midrst_pre_en: got %b want 1", a_en);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (a_en !== 1'b0) $display("FAIL midrst_async_en: got %b want 0", a_en);
    else n_pass++;
    n_checks++;
    if (a_lcd_data !== 8'h00 || a_busy !== 1'b1)
      $display("FAIL midrst_state: got data=%h busy=%b want 00/1", a_lcd_data, a_busy);
    else n_pass++;
    tick();
    tick();
    rst = 1'b1;
    n_checks++;
    if (a_ready !== 1'b0 || a_done !== 1'b0)
      $display("FAIL midrst_release: got ready=%b done=%b want 0/0", a_ready, a_done);
    else n_pass++;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (a_en && a_first < 0) begin a_first = cyc; a_byte = a_lcd_data; end
      if (b_en && b_first < 0) begin b_first = cyc; b_byte = b_lcd_data; end
      tick();
    end
    n_checks++;
    if (a_first != 23 || a_byte !== 8'h30)
      $display("FAIL midrst_reinit8: got cyc=%0d byte=%h want 23/30", a_first, a_byte);
    else n_pass++;
    n_checks++;
    if (b_first != 23 || b_byte !== 8'h30)
      $display("FAIL midrst_reinit4: got cyc=%0d byte=%h want 23/30", b_first, b_byte);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_char_write();
    test_clear_cmd();
    test_4bit_write();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 750000: power-up delay in clk cycles before the first init write (15 ms at 50 MHz).
REQ-002 SHALL have parameter SETUP_CYC, default 3: cycles lcd_rs/lcd_data are stable with lcd_en low before the enable pulse.
REQ-003 SHALL have parameter EN_HIGH_CYC, default 25: lcd_en high width in cycles.
REQ-004 SHALL have parameter CMD_WAIT_CYC, default 2000: post-write wait for ordinary commands and data.
REQ-005 SHALL have parameter CLR_WAIT_CYC, default 82000: post-write wait for clear/home commands and the first init write.
REQ-006 SHALL have parameter BUS_4BIT, default 0: 0 selects the 8-bit bus, 1 selects the 4-bit bus.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 in_valid  in  1  write request.
REQ-010 in_rs  in  1  0 = command, 1 = character data.
REQ-011 in_data  in  8  byte to write.
REQ-012 in_ready  out  1  controller can accept a request.
REQ-013 init_done  out  1  init sequence complete; stays high until reset.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 lcd_data  out  8  LCD data bus.
REQ-016 lcd_rw  out  1  tied 0 (write only).
REQ-017 lcd_rs  out  1  LCD register select.
REQ-018 lcd_en  out  1  LCD enable strobe.

Function
REQ-019 SHALL implement states PWRUP, INIT_LOAD, SETUP, EN_HI, HOLD, WAIT and IDLE.
REQ-020 PWRUP SHALL count PWRUP_CYC cycles, then go to INIT_LOAD.
REQ-021 The init ROM, issued in order with rs=0, SHALL be:
- 8-bit bus: 0x30, 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06.
- 4-bit bus: the single nibbles 0x3, 0x3, 0x3, 0x2, then full bytes 0x28, 0x0C, 0x01, 0x06.
REQ-022 Each write SHALL run SETUP for SETUP_CYC cycles (lcd_en=0), EN_HI for EN_HIGH_CYC cycles (lcd_en=1), HOLD for 1 cycle (lcd_en=0, bus held), then WAIT.
REQ-023 The WAIT length SHALL be CLR_WAIT_CYC when rs=0 and data[7:2]==0 (clear/home), or when the write is the first init write; otherwise it SHALL be CMD_WAIT_CYC.
REQ-024 After the last init write's WAIT, the block SHALL set init_done=1 and enter IDLE.
REQ-025 in_ready SHALL equal (state==IDLE && init_done), computed combinationally from registered state.
REQ-026 A transfer SHALL occur at a rising edge where in_valid && in_ready; in_rs and in_data SHALL be captured at that edge, and in_valid while not ready SHALL be ignored (not queued).
REQ-027 The first SETUP cycle SHALL be the cycle after acceptance, and in_ready SHALL be low for exactly SETUP_CYC+EN_HIGH_CYC+1+WAIT cycles.
REQ-028 In 8-bit mode, lcd_data SHALL carry the full byte.
REQ-029 In 4-bit mode:
- lcd_data[7:4] SHALL carry the high nibble, then the low nibble, each with its own SETUP/EN_HI/HOLD.
- There SHALL be no wait between the two nibbles; WAIT follows the low nibble only.
- lcd_data[3:0] SHALL be 0.
REQ-030 lcd_rs and lcd_data SHALL remain unchanged from the start of SETUP through the end of HOLD.
REQ-031 In IDLE, lcd_en SHALL be 0 and lcd_data/lcd_rs SHALL hold their last values.
REQ-032 All cycle counters SHALL be sized $clog2(max parameter + 1) and SHALL not wrap; each terminal count SHALL be compared as count == N-1.
REQ-033 A parameter value of 0 for SETUP_CYC or any WAIT SHALL skip that state; EN_HIGH_CYC SHALL be >= 1.

Reset
REQ-034 While rst=0, the block SHALL drive state=PWRUP, all counters 0, init_done=0, in_ready=0, busy=1, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
REQ-035 Assertion of rst in any state, including mid-pulse, SHALL force lcd_en low immediately (asynchronously).
REQ-036 On release, the full power-up and init sequence SHALL restart, and any pending transfer SHALL be discarded.

Verification
Bench parameters: PWRUP_CYC=20, SETUP_CYC=2, EN_HIGH_CYC=4, CMD_WAIT_CYC=10, CLR_WAIT_CYC=30.
REQ-037 Reset, then release -> lcd_en stays 0 for 20 cycles; first lcd_en rise at cycle 23 with lcd_data=0x30, lcd_rs=0.
REQ-038 8-bit init -> seven lcd_en pulses with bytes 30,30,30,38,0C,01,06; WAIT of 30 after the first write and after 0x01, 10 after all others; init_done rises after the final wait.
REQ-039 After init, in_valid=1, in_rs=1, in_data=0x41 for one cycle -> lcd_rs=1, lcd_data=0x41, lcd_en high for 4 cycles starting 3 cycles after acceptance; in_ready low for 17 cycles.
REQ-040 Command 0x01 via the handshake -> in_ready low for 37 cycles; a second in_valid during busy is not accepted.
REQ-041 BUS_4BIT=1, write 0xA5 data -> lcd_data 0xA0 pulse, then 0x50 pulse back-to-back (7 cycles apart); lcd_data[3:0]=0 throughout.
REQ-042 rst=0 asserted during EN_HI -> lcd_en=0 within the same cycle; after release the power-up delay and init repeat from the first byte 0x30.
